// File: rtl/div_16bit_seq.sv
// Sequential restoring divider: N_WIDTH-bit dividend / D_WIDTH-bit divisor, one quotient bit
// per clock, with a start/busy/done handshake. Divide-by-zero completes without iterating.
module div_16bit_seq #(
   parameter int unsigned N_WIDTH = 32,
   parameter int unsigned D_WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_WIDTH-1:0] dividend,
   input  logic [D_WIDTH-1:0] divisor,
   output logic               busy,
   output logic               done,
   output logic [N_WIDTH-1:0] quotient,
   output logic [D_WIDTH-1:0] remainder,
   output logic               div_by_zero
);

   localparam int unsigned CntW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [N_WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB first, quotient bits shift in
   logic [D_WIDTH-1:0] dsr_q, dsr_d;
   logic [D_WIDTH-1:0] rem_q, rem_d;
   logic [N_WIDTH-1:0] quo_q, quo_d;
   logic [D_WIDTH-1:0] rmd_q, rmd_d;
   logic               dbz_q, dbz_d;

   logic [D_WIDTH:0]   partial;
   logic               q_bit;
   logic [D_WIDTH-1:0] step_rem;
   logic [N_WIDTH-1:0] step_dvd;

   // One restoring step; the extra partial bit keeps the compare exact.
   always_comb begin
      partial  = {rem_q, dvd_q[N_WIDTH-1]};
      q_bit    = (partial >= {1'b0, dsr_q});
      step_rem = q_bit ? D_WIDTH'(partial - {1'b0, dsr_q}) : D_WIDTH'(partial);
      step_dvd = {dvd_q[N_WIDTH-2:0], q_bit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               dvd_d = dividend;
               dsr_d = divisor;
               rem_d = '0;
               cnt_d = '0;
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  quo_d   = '1;
                  rmd_d   = dividend[D_WIDTH-1:0];
                  dbz_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               quo_d   = step_dvd;
               rmd_d   = step_rem;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

endmodule
